pack_arb: RTL and testbench

Round-robin scheduler sharing one `pack` lane-compaction unit among R requesters. Each requester offers N-lane beats grouped into packets. The arbiter locks onto one requester for a whole packet and forwards its beats one per cycle into registered packer-input signals. It sits directly upstream of `pack`, with its `pk_*` outputs wired to `pack`'s `in_pass` / `in_w` / `in_vld_w`.

---
 rtl/pack_arb.sv | 145 ++++++++++++++
 tb/tb_pack_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pack_arb.sv
// Round-robin scheduler that locks one requester per packet and feeds its beats to a shared packer.
// Latency: one cycle from accept to the registered pk_* outputs; one beat per cycle, no inter-packet bubble.
// Backpressure: stall or an idle owner holds everything; req_rdy is combinational on req_vld/state/ptr/stall.
module pack_arb #(
  parameter int R    = 4,
  parameter int N    = 8,
  parameter int W    = 32,
  parameter int MAXB = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         req_vld,
  input  logic [R-1:0]         req_last,
  input  logic [R*N-1:0]       req_mask,
  input  logic [R*N*W-1:0]     req_w,
  output logic [R-1:0]         req_rdy,
  input  logic                 stall,
  output logic                 pk_pass_r,
  output logic [N*W-1:0]       pk_w_r,
  output logic [N-1:0]         pk_vld_r,
  output logic [$clog2(R)-1:0] pk_src_r,
  output logic                 pk_last_r,
  output logic                 err_r
);

  localparam int SW = $clog2(R);
  localparam int BW = $clog2(MAXB + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  owner_q, owner_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic           pk_pass_q, pk_pass_d;
  logic           pk_last_q, pk_last_d;
  logic [SW-1:0]  pk_src_q, pk_src_d;
  logic [N-1:0]   pk_vld_q, pk_vld_d;
  logic [N*W-1:0] pk_w_q, pk_w_d;
  logic           err_q, err_d;

  logic [SW-1:0]  gnt_idx;
  logic           gnt_found;
  logic           acc;
  logic           acc_last;
  logic           forced;

  // Grant selection: owner while locked, otherwise first valid requester after ptr.
  always_comb begin
    gnt_idx   = owner_q;
    gnt_found = 1'b0;
    req_rdy   = '0;
    if (state_q == LOCK) begin
      gnt_found = ~stall;
    end else if (!stall) begin
      for (int k = 1; k <= R; k++) begin
        if (!gnt_found && req_vld[(int'(ptr_q) + k) % R]) begin
          gnt_found = 1'b1;
          gnt_idx   = SW'((int'(ptr_q) + k) % R);
        end
      end
    end
    if (gnt_found) req_rdy[gnt_idx] = 1'b1;
  end

  // Accept qualification and forced-release detection on the granted beat.
  always_comb begin
    acc      = gnt_found & req_vld[gnt_idx];
    acc_last = req_last[gnt_idx];
    if (state_q == LOCK) begin
      forced = acc & ~acc_last & ((int'(bcnt_q) + 1) == MAXB);
    end else begin
      forced = acc & ~acc_last & (MAXB == 1);
    end
  end

  // Next-state: lock bookkeeping, pointer update and packer-input capture.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    err_d     = err_q;
    pk_pass_d = acc;
    pk_last_d = acc & (acc_last | forced);
    pk_src_d  = pk_src_q;
    pk_vld_d  = pk_vld_q;
    pk_w_d    = pk_w_q;
    if (acc) begin
      pk_src_d = gnt_idx;
      pk_vld_d = req_mask[int'(gnt_idx)*N +: N];
      pk_w_d   = req_w[int'(gnt_idx)*N*W +: N*W];
      if (acc_last || forced) begin
        state_d = IDLE;
        ptr_d   = gnt_idx;
        bcnt_d  = '0;
      end else if (state_q == IDLE) begin
        state_d = LOCK;
        owner_d = gnt_idx;
        bcnt_d  = BW'(1);
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
      end
      if (forced) err_d = 1'b1;
    end
  end

  // Control and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= SW'(R - 1);
      bcnt_q    <= '0;
      err_q     <= 1'b0;
      pk_pass_q <= 1'b0;
      pk_last_q <= 1'b0;
      pk_src_q  <= '0;
      pk_vld_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      bcnt_q    <= bcnt_d;
      err_q     <= err_d;
      pk_pass_q <= pk_pass_d;
      pk_last_q <= pk_last_d;
      pk_src_q  <= pk_src_d;
      pk_vld_q  <= pk_vld_d;
    end
  end

  // Beat data register; no reset since it is only meaningful alongside pk_pass_r.
  always_ff @(posedge clk) begin
    pk_w_q <= pk_w_d;
  end

  assign pk_pass_r = pk_pass_q;
  assign pk_last_r = pk_last_q;
  assign pk_src_r  = pk_src_q;
  assign pk_vld_r  = pk_vld_q;
  assign pk_w_r    = pk_w_q;
  assign err_r     = err_q;

endmodule

// File: tb/tb_pack_arb.sv
module tb_pack_arb;

  localparam int R    = 4;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXB = 4;

  logic             clk;
  logic             rst;
  logic [R-1:0]     req_vld;
  logic [R-1:0]     req_last;
  logic [R*N-1:0]   req_mask;
  logic [R*N*W-1:0] req_w;
  logic [R-1:0]     req_rdy;
  logic             stall;
  logic             pk_pass_r;
  logic [N*W-1:0]   pk_w_r;
  logic [N-1:0]     pk_vld_r;
  logic [1:0]       pk_src_r;
  logic             pk_last_r;
  logic             err_r;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [R*N-1:0] MASKS = {4'h8, 4'h4, 4'h3, 4'hF};

  pack_arb #(.R(R), .N(N), .W(W), .MAXB(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_last  (req_last),
    .req_mask  (req_mask),
    .req_w     (req_w),
    .req_rdy   (req_rdy),
    .stall     (stall),
    .pk_pass_r (pk_pass_r),
    .pk_w_r    (pk_w_r),
    .pk_vld_r  (pk_vld_r),
    .pk_src_r  (pk_src_r),
    .pk_last_r (pk_last_r),
    .err_r     (err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] beat_of(input int i);
    logic [N*W-1:0] b;
    for (int l = 0; l < N; l++) b[l*W +: W] = 8'(16 * (i + 1) + l);
    return b;
  endfunction

  function automatic logic [N-1:0] mask_of(input int i);
    logic [R*N-1:0] m;
    m = MASKS;
    return m[i*N +: N];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat_chk(input string tag, input int src, input logic last);
    chk({tag, "_pass"}, 64'(pk_pass_r), 64'(1));
    chk({tag, "_src"},  64'(pk_src_r),  64'(src));
    chk({tag, "_last"}, 64'(pk_last_r), 64'(last));
    chk({tag, "_vld"},  64'(pk_vld_r),  64'(mask_of(src)));
    chk({tag, "_w"},    64'(pk_w_r),    64'(beat_of(src)));
  endtask

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    req_vld  = '0;
    req_last = '0;
    req_mask = MASKS;
    for (int i = 0; i < R; i++) req_w[i*N*W +: N*W] = beat_of(i);
    tick();
    tick();

    // Reset state
    chk("rst_pass", 64'(pk_pass_r), 64'(0));
    chk("rst_last", 64'(pk_last_r), 64'(0));
    chk("rst_src",  64'(pk_src_r),  64'(0));
    chk("rst_vld",  64'(pk_vld_r),  64'(0));
    chk("rst_err",  64'(err_r),     64'(0));
    rst = 1'b0;
    #1;
    chk("idle_rdy_none", 64'(req_rdy), 64'(0));

    // Round-robin fairness with single-beat packets: 0,1,2,3,0,1
    req_vld  = 4'hF;
    req_last = 4'hF;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("rr_rdy", 64'(req_rdy), 64'(1 << (c % 4)));
      tick();
      beat_chk("rr_beat", c % 4, 1'b1);
    end

    // Packet lock: requester 2 three beats while requester 1 waits
    req_vld  = 4'b0110;
    req_last = 4'b0010;
    #1;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) req_last[2] = 1'b1;
      #1;
      chk("lock_rdy", 64'(req_rdy), 64'(4'b0100));
      tick();
      beat_chk("lock_beat", 2, (b == 2));
    end
    req_last = 4'b0010;
    #1;
    chk("lock_next_rdy", 64'(req_rdy), 64'(4'b0010));
    tick();
    beat_chk("lock_next_beat", 1, 1'b1);

    // Stall mid-packet of requester 0, others valid
    req_vld  = 4'b0001;
    req_last = 4'b0000;
    #1;
    chk("st_rdy0", 64'(req_rdy), 64'(4'b0001));
    tick();
    beat_chk("st_beat0", 0, 1'b0);
    req_vld  = 4'hF;
    req_last = 4'b1110;
    stall    = 1'b1;
    #1;
    chk("st_rdy_hold1", 64'(req_rdy), 64'(0));
    tick();
    chk("st_pass_hold1", 64'(pk_pass_r), 64'(0));
    req_last = 4'b1111;
    #1;
    chk("st_rdy_hold2", 64'(req_rdy), 64'(0));
    tick();
    chk("st_pass_hold2", 64'(pk_pass_r), 64'(0));
    stall    = 1'b0;
    req_last = 4'b1110;
    #1;
    chk("st_rdy_resume", 64'(req_rdy), 64'(4'b0001));
    tick();
    beat_chk("st_beat1", 0, 1'b0);
    req_last = 4'b1111;
    #1;
    chk("st_rdy_end", 64'(req_rdy), 64'(4'b0001));
    tick();
    beat_chk("st_beat2", 0, 1'b1);

    // Forced release after MAXB beats from requester 3
    req_vld  = 4'b1001;
    req_last = 4'b0001;
    #1;
    for (int b = 0; b < 4; b++) begin
      chk("fr_rdy", 64'(req_rdy), 64'(4'b1000));
      tick();
      beat_chk("fr_beat", 3, (b == 3));
      chk("fr_err", 64'(err_r), 64'(b == 3));
    end
    chk("fr_next_rdy", 64'(req_rdy), 64'(4'b0001));
    tick();
    beat_chk("fr_next_beat", 0, 1'b1);
    chk("fr_err_sticky0", 64'(err_r), 64'(1));
    req_vld = '0;
    tick();
    chk("fr_idle_pass", 64'(pk_pass_r), 64'(0));
    chk("fr_err_sticky1", 64'(err_r), 64'(1));
    tick();
    chk("fr_err_sticky2", 64'(err_r), 64'(1));

    // Reset during requester 1's second beat
    req_vld  = 4'b0010;
    req_last = 4'b0000;
    #1;
    chk("rl_rdy", 64'(req_rdy), 64'(4'b0010));
    tick();
    beat_chk("rl_beat0", 1, 1'b0);
    rst = 1'b1;
    tick();
    chk("rl_pass", 64'(pk_pass_r), 64'(0));
    chk("rl_last", 64'(pk_last_r), 64'(0));
    chk("rl_err",  64'(err_r),     64'(0));
    rst = 1'b0;

    // Zero-mask single beat from requester 0, then pointer moves on to 1
    req_vld  = 4'b0011;
    req_last = 4'b0011;
    req_mask[3:0] = 4'h0;
    #1;
    chk("zm_rdy", 64'(req_rdy), 64'(4'b0001));
    tick();
    chk("zm_pass", 64'(pk_pass_r), 64'(1));
    chk("zm_vld",  64'(pk_vld_r),  64'(0));
    chk("zm_last", 64'(pk_last_r), 64'(1));
    chk("zm_src",  64'(pk_src_r),  64'(0));
    chk("zm_w",    64'(pk_w_r),    64'(beat_of(0)));
    req_mask = MASKS;
    #1;
    chk("zm_next_rdy", 64'(req_rdy), 64'(4'b0010));
    tick();
    beat_chk("zm_next_beat", 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
